abr_prim_alert_receiver: RTL
============================

// Module: abr_prim_alert_receiver
// PURPOSE
//  Handler-side end of the differential alert protocol: decodes alert_tx_t
//  (alert_p/alert_n) from an alert sender and drives alert_rx_t (ping_p/n,
//  ack_p/n) back. Performs the 4-phase alert/ack handshake, issues pings and
//  matches ping responses. Flags differential-pair integrity errors. One
//  instance per alert source in the alert handler.
// PARAMETERS
//  AsyncOn        0  1: sender is on another clock; add NumSyncStages flops on alert_p/n
//  NumSyncStages  2  synchroniser depth when AsyncOn=1 (>=2); ignored when AsyncOn=0
// PORTS
//  clk_i         in   1  clock; single clock domain
//  rst_ni        in   1  reset, asynchronous, active-low
//  ping_req_i    in   1  request a ping; honoured only when no ping is pending
//  ping_ok_o     out  1  1-cycle pulse: pending ping answered by sender
//  integ_fail_o  out  1  alert_p==alert_n sampled; asserted every cycle the fault persists
//  alert_o       out  1  1-cycle pulse: genuine alert received (no ping pending)
//  alert_tx_i    in   2  alert_tx_t {alert_p, alert_n} from sender
//  alert_rx_o    out  4  alert_rx_t {ping_p, ping_n, ack_p, ack_n} to sender
// BEHAVIOUR
//  Reset: alert_rx_o=ALERT_RX_DEFAULT (ping_p=0,ping_n=1,ack_p=0,ack_n=1);
//   ping_ok_o=integ_fail_o=alert_o=0; state=Idle; ping_pending=0.
//  Decode (after optional sync): p&~n = asserted; ~p&n = deasserted; p==n = sigint.
//  ack_p=ack_q, ack_n=~ack_q; ping_p=ping_q, ping_n=~ping_q (all registered).
//  Ping: ping_req_i & ~ping_pending -> ping_q toggles, ping_pending=1 next cycle.
//   ping_req_i while pending is ignored (no toggle, no queueing).
//  FSM (alert_rx_state_e):
//   Idle:      ack_q=0. asserted -> HsAckWait, ack_q<=1; if ping_pending:
//              ping_ok_o pulse, clear pending; else alert_o pulse.
//   HsAckWait: hold ack_q=1 until deasserted -> Pause0, ack_q<=0.
//   Pause0 -> Pause1 -> Idle unconditionally (ack_q=0; blocks re-trigger).
//  Sigint in any state: integ_fail_o=1, state<=Idle, ack_q<=0, no alert_o /
//   ping_ok_o that cycle; ping_pending and ping_q unchanged.
//  Outputs alert_o/ping_ok_o/integ_fail_o are registered: asserted 1 cycle
//   after the decoded sample (+NumSyncStages when AsyncOn=1).
//  Simultaneous ping_req_i and asserted in Idle with pending=0: classified as
//   alert_o; ping is then issued and stays pending.
//  Alert held asserted across Pause1->Idle: re-detected as a new event.
//  Asynchronous reset mid-handshake: immediate return to reset values.
//  Illegal state encoding: treat as Idle, assert integ_fail_o.
// STRUCTURE
//  abr_prim_alert_pkg: reuse alert_tx_t, alert_rx_t, ALERT_RX_DEFAULT; add
//   typedef enum logic [1:0] alert_rx_state_e {Idle, HsAckWait, Pause0, Pause1}.
//  Sub-module abr_prim_diff_decode: optional synchroniser + differential
//   decode (outputs level, sigint); reused by the sender for ping/ack.
// TESTING
//  1. Reset release, alert_tx={0,1} idle -> alert_rx_o=4'b0101, all outputs 0.
//  2. alert_tx={1,0} for 3 cycles, then {0,1} after ack_p=1 -> alert_o one
//     pulse, ack_p high until deassert, back to Idle after Pause0/Pause1.
//  3. ping_req_i pulse -> ping_p 0->1; sender answers {1,0} -> ping_ok_o pulse,
//     alert_o stays 0; second ping_req_i -> ping_p 1->0.
//  4. alert_tx={1,1} for 2 cycles in HsAckWait -> integ_fail_o 2 cycles,
//     ack_p drops to 0, no alert_o; {0,0} in Idle likewise.
//  5. ping_req_i and alert asserted same cycle in Idle -> alert_o pulse; next
//     handshake response -> ping_ok_o pulse.
//  6. rst_ni low during HsAckWait with ping pending -> alert_rx_o=4'b0101,
//     pending cleared; AsyncOn=1 repeat of 2 -> alert_o 2 cycles later.

Source files
------------

// File: rtl/abr_prim_alert_pkg.sv
// Shared types for the differential alert protocol (sender <-> receiver).
package abr_prim_alert_pkg;

  // Sender -> receiver: one differential pair carrying the alert level.
  typedef struct packed {
    logic alert_p;
    logic alert_n;
  } alert_tx_t;

  // Receiver -> sender: ping request pair and ack pair.
  typedef struct packed {
    logic ping_p;
    logic ping_n;
    logic ack_p;
    logic ack_n;
  } alert_rx_t;

  parameter alert_tx_t ALERT_TX_DEFAULT = '{alert_p: 1'b0, alert_n: 1'b1};
  parameter alert_rx_t ALERT_RX_DEFAULT = '{ping_p: 1'b0, ping_n: 1'b1,
                                            ack_p: 1'b0, ack_n: 1'b1};

  // Receiver handshake state.
  typedef enum logic [1:0] {
    Idle      = 2'd0,
    HsAckWait = 2'd1,
    Pause0    = 2'd2,
    Pause1    = 2'd3
  } alert_rx_state_e;

endpackage

// File: rtl/abr_prim_alert_receiver_if.sv
// Bundle for one alert link between a sender and the alert handler.
//
// Handshake: the sender raises alert (p=1,n=0); the receiver answers with
// ack (ack_p=1) and holds it until the sender lowers alert (p=0,n=1); the
// receiver then lowers ack and pauses two cycles before it accepts a new
// alert. A ping is a toggle of ping_p/ping_n; the sender answers a ping with
// the same alert handshake. Any pair with p==n is an integrity error.
interface abr_prim_alert_receiver_if;
  import abr_prim_alert_pkg::*;

  alert_tx_t alert_tx;
  alert_rx_t alert_rx;

  // master: the alert sender
  modport master (output alert_tx, input alert_rx);
  // slave: the alert receiver in the handler
  modport slave (input alert_tx, output alert_rx);

endinterface

// File: rtl/abr_prim_diff_decode.sv
// Optional synchroniser plus differential-pair decode.
// level_o is 1 for p&~n; sigint_o flags p==n (level_o is then 0).
module abr_prim_diff_decode #(
  parameter bit          AsyncOn       = 1'b0,
  parameter int unsigned NumSyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic diff_pi,
  input  logic diff_ni,
  output logic level_o,
  output logic sigint_o
);

  logic diff_p, diff_n;

  if (AsyncOn) begin : gen_sync
    logic [NumSyncStages-1:0] sync_p_q, sync_n_q;

    // Synchroniser chains; reset to the idle pair value (p=0, n=1).
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync_p_q <= '0;
        sync_n_q <= '1;
      end else begin
        sync_p_q <= {sync_p_q[NumSyncStages-2:0], diff_pi};
        sync_n_q <= {sync_n_q[NumSyncStages-2:0], diff_ni};
      end
    end

    assign diff_p = sync_p_q[NumSyncStages-1];
    assign diff_n = sync_n_q[NumSyncStages-1];
  end else begin : gen_no_sync
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign diff_p = diff_pi;
    assign diff_n = diff_ni;
  end

  // Decode: any equal pair is an integrity fault, never a valid level.
  always_comb begin
    level_o  = diff_p & ~diff_n;
    sigint_o = ~(diff_p ^ diff_n);
  end

endmodule

// File: rtl/abr_prim_alert_receiver.sv
// Handler-side end of the differential alert protocol: runs the alert/ack
// handshake, issues pings, matches ping responses, flags pair faults.
module abr_prim_alert_receiver
  import abr_prim_alert_pkg::*;
#(
  parameter bit          AsyncOn       = 1'b0,
  parameter int unsigned NumSyncStages = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      ping_req_i,
  output logic      ping_ok_o,
  output logic      integ_fail_o,
  output logic      alert_o,
  input  alert_tx_t alert_tx_i,
  output alert_rx_t alert_rx_o
);

  logic alert_level, alert_sigint;

  abr_prim_diff_decode #(
    .AsyncOn       (AsyncOn),
    .NumSyncStages (NumSyncStages)
  ) u_decode (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .diff_pi  (alert_tx_i.alert_p),
    .diff_ni  (alert_tx_i.alert_n),
    .level_o  (alert_level),
    .sigint_o (alert_sigint)
  );

  alert_rx_state_e state_q;
  logic ack_q, ping_q, ping_pending_q;
  logic alert_q, ping_ok_q, integ_fail_q;

  // Handshake FSM, ping tracking and registered event pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= Idle;
      ack_q          <= 1'b0;
      ping_q         <= 1'b0;
      ping_pending_q <= 1'b0;
      alert_q        <= 1'b0;
      ping_ok_q      <= 1'b0;
      integ_fail_q   <= 1'b0;
    end else begin
      alert_q      <= 1'b0;
      ping_ok_q    <= 1'b0;
      integ_fail_q <= 1'b0;

      // A new ping is only launched when none is outstanding; an alert in
      // the same cycle was already classified against the old pending flag.
      if (ping_req_i && !ping_pending_q) begin
        ping_q         <= ~ping_q;
        ping_pending_q <= 1'b1;
      end

      if (alert_sigint) begin
        // Pair fault: abandon any handshake, keep ping bookkeeping intact.
        integ_fail_q <= 1'b1;
        state_q      <= Idle;
        ack_q        <= 1'b0;
      end else begin
        case (state_q)
          Idle: begin
            ack_q <= 1'b0;
            if (alert_level) begin
              state_q <= HsAckWait;
              ack_q   <= 1'b1;
              if (ping_pending_q) begin
                ping_ok_q      <= 1'b1;
                ping_pending_q <= 1'b0;
              end else begin
                alert_q <= 1'b1;
              end
            end
          end
          HsAckWait: begin
            if (!alert_level) begin
              state_q <= Pause0;
              ack_q   <= 1'b0;
            end
          end
          Pause0: begin
            ack_q   <= 1'b0;
            state_q <= Pause1;
          end
          Pause1: begin
            ack_q   <= 1'b0;
            state_q <= Idle;
          end
          default: begin
            state_q      <= Idle;
            ack_q        <= 1'b0;
            integ_fail_q <= 1'b1;
          end
        endcase
      end
    end
  end

  // Differential outputs are direct copies / inversions of registers.
  always_comb begin
    alert_rx_o   = '{ping_p: ping_q, ping_n: ~ping_q, ack_p: ack_q, ack_n: ~ack_q};
    alert_o      = alert_q;
    ping_ok_o    = ping_ok_q;
    integ_fail_o = integ_fail_q;
  end

endmodule
